// File: rtl/stream_mux_4x1_rr_if.sv
// Purpose: bundles the four input channels and the single output channel of the 4:1 stream mux.
// Latency: none, because this is wiring only.
// Backpressure: in_ready is driven by the mux and out_ready by the downstream sink.
interface stream_mux_4x1_rr_if #(
    parameter int DATA_W = 8
);
    logic [3:0]          in_valid;
    logic [3:0]          in_ready;
    logic [4*DATA_W-1:0] in_data;
    logic [3:0]          in_last;
    logic                out_valid;
    logic                out_ready;
    logic [DATA_W-1:0]   out_data;
    logic [1:0]          out_sel;
    logic                out_last;

    // Mux side: consumes the input channels and produces the output channel.
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_sel, out_last
    );

    // Environment side: drives the input channels and sinks the output channel.
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_sel, out_last
    );
endinterface

// File: rtl/stream_mux_4x1_rr.sv
// Purpose: merges 4 valid/ready channels into one registered channel using round-robin; out_sel carries the source index.
// Latency: 1 cycle from the accepting edge to out_*. The mux sustains one beat per clock when out_ready is held high.
// Backpressure: in_ready is combinational and at most one-hot; it is all-zero while the output register is stalled or reset is asserted.
// Optional build macro STREAM_MUX_PKT_LOCK_EN: holds the grant on one channel from the first beat of a packet until its in_last beat.
module stream_mux_4x1_rr #(
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    stream_mux_4x1_rr_if.slave  bus
);

    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q,  out_data_d;
    logic [1:0]          out_sel_q,   out_sel_d;
    logic                out_last_q,  out_last_d;
    logic [1:0]          rr_ptr_q,    rr_ptr_d;
`ifdef STREAM_MUX_PKT_LOCK_EN
    logic                lock_q,      lock_d;
`endif

    logic                load;
    logic                grant_vld;
    logic [1:0]          grant_idx;
    logic [DATA_W-1:0]   grant_dat;

    // The output register can take a new beat when it is empty or its beat is leaving this cycle.
    assign load = !out_valid_q || bus.out_ready;

    // Round-robin search from rr_ptr. The descending loop lets the lowest offset win.
    always_comb begin
        grant_idx = rr_ptr_q;
        grant_vld = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            if (bus.in_valid[rr_ptr_q + 2'(k)]) begin
                grant_idx = rr_ptr_q + 2'(k);
                grant_vld = 1'b1;
            end
        end
`ifdef STREAM_MUX_PKT_LOCK_EN
        // While a packet is open, out_sel still holds the channel that opened it.
        if (lock_q) begin
            grant_idx = out_sel_q;
            grant_vld = bus.in_valid[out_sel_q];
        end
`endif
    end

    // Select the data of the granted channel.
    always_comb begin
        grant_dat = '0;
        for (int i = 0; i < 4; i++) begin
            if (grant_idx == 2'(i)) begin
                grant_dat = bus.in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // One-hot accept for the winner. It is forced to zero while stalled or in reset.
    assign bus.in_ready = (rst_n && load && grant_vld) ? (4'b0001 << grant_idx) : 4'b0000;

    // Next-state logic for the output register and the arbitration pointer.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_last_d  = out_last_q;
        rr_ptr_d    = rr_ptr_q;
`ifdef STREAM_MUX_PKT_LOCK_EN
        lock_d      = lock_q;
`endif
        if (load) begin
            out_valid_d = grant_vld;
            if (grant_vld) begin
                out_data_d = grant_dat;
                out_sel_d  = grant_idx;
                out_last_d = bus.in_last[grant_idx];
`ifdef STREAM_MUX_PKT_LOCK_EN
                // Stay on this channel until its last beat. The pointer moves on only when the packet closes.
                lock_d = !bus.in_last[grant_idx];
                if (bus.in_last[grant_idx]) begin
                    rr_ptr_d = grant_idx + 2'd1;
                end
`else
                rr_ptr_d = grant_idx + 2'd1;
`endif
            end
        end
    end

    // State registers. Reset drops any held beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= 2'd0;
            out_last_q  <= 1'b0;
            rr_ptr_q    <= 2'd0;
`ifdef STREAM_MUX_PKT_LOCK_EN
            lock_q      <= 1'b0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_last_q  <= out_last_d;
            rr_ptr_q    <= rr_ptr_d;
`ifdef STREAM_MUX_PKT_LOCK_EN
            lock_q      <= lock_d;
`endif
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;
    assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_stream_mux_4x1_rr.sv
// Purpose: testbench for stream_mux_4x1_rr. It uses a queue-free reference model of round-robin grant and holding-register behaviour.
// Latency: the model predicts the registered output one edge after acceptance.
// Backpressure: out_ready is driven directly by the directed sequences.
module tb_stream_mux_4x1_rr;
    localparam int DATA_W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    stream_mux_4x1_rr_if #(.DATA_W(DATA_W)) bus ();

    stream_mux_4x1_rr #(.DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state: the beat held at the output and the next channel to favour.
    int              m_ptr     = 0;
    bit              m_lock    = 1'b0;
    int              m_lock_ch = 0;
    bit              m_vld     = 1'b0;
    logic [7:0]      m_data    = 8'h00;
    int              m_sel     = 0;
    bit              m_last    = 1'b0;

    // Returns the channel that must win this cycle, or -1 if no channel can win.
    function automatic int m_winner();
        if (m_lock) return bus.in_valid[m_lock_ch] ? m_lock_ch : -1;
        for (int k = 0; k < 4; k++)
            if (bus.in_valid[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
        return -1;
    endfunction

    function automatic logic [3:0] m_ready();
        int w;
        if (!rst_n) return 4'b0000;
        if (m_vld && !bus.out_ready) return 4'b0000;
        w = m_winner();
        if (w < 0) return 4'b0000;
        return 4'(1 << w);
    endfunction

    function automatic logic [7:0] data_of(input int ch);
        return bus.in_data[ch*DATA_W +: DATA_W];
    endfunction

    // Advance the model on each edge, and clear it as soon as reset is asserted.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ptr  <= 0;
            m_lock <= 1'b0;
            m_vld  <= 1'b0;
            m_data <= 8'h00;
            m_sel  <= 0;
            m_last <= 1'b0;
        end else if (!m_vld || bus.out_ready) begin
            if (m_winner() >= 0) begin
                m_vld  <= 1'b1;
                m_data <= data_of(m_winner());
                m_sel  <= m_winner();
                m_last <= bus.in_last[m_winner()];
`ifdef STREAM_MUX_PKT_LOCK_EN
                if (!bus.in_last[m_winner()]) begin
                    m_lock    <= 1'b1;
                    m_lock_ch <= m_winner();
                end else begin
                    m_lock <= 1'b0;
                    m_ptr  <= (m_winner() + 1) % 4;
                end
`else
                m_ptr <= (m_winner() + 1) % 4;
`endif
            end else begin
                m_vld <= 1'b0;
            end
        end
    end

    // Compare the DUT against the model on every falling edge outside reset.
    always @(negedge clk) begin
        if (rst_n) begin
            check("model_in_ready", bus.in_ready, m_ready());
            check("model_out_valid", bus.out_valid, m_vld);
            check("model_out_data", bus.out_data, m_data);
            check("model_out_sel", bus.out_sel, m_sel);
            check("model_out_last", bus.out_last, m_last);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int          beat;
    logic [3:0]  rdy;
    int          exp_sel [4];
    int          exp_last[4];

    initial begin
        bus.in_valid  = 4'b0000;
        bus.in_data   = '0;
        bus.in_last   = 4'b0000;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Check the values the DUT comes out of reset with.
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_sel", bus.out_sel, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_rr_ptr", dut.rr_ptr_q, 0);

        // T2: ch2 sends a single beat.
        tick();
        bus.in_valid  = 4'b0100;
        bus.in_data   = {8'h00, 8'hA5, 8'h00, 8'h00};
        bus.out_ready = 1'b1;
        #1 check("t2_in_ready", bus.in_ready, 4'b0100);
        tick();
        bus.in_valid = 4'b0000;
        check("t2_out_valid", bus.out_valid, 1);
        check("t2_out_data", bus.out_data, 8'hA5);
        check("t2_out_sel", bus.out_sel, 2);
        check("t2_rr_ptr", dut.rr_ptr_q, 3);
        check("t2_model_ptr", m_ptr, 3);

        // T5: the pointer is at 3 and only ch1 is valid, so the search wraps and skips.
        bus.in_valid = 4'b0010;
        bus.in_data  = {8'h00, 8'h00, 8'h5A, 8'h00};
        #1 check("t5_in_ready", bus.in_ready, 4'b0010);
        tick();
        bus.in_valid = 4'b0000;
        check("t5_out_sel", bus.out_sel, 1);
        check("t5_out_data", bus.out_data, 8'h5A);
        check("t5_rr_ptr", dut.rr_ptr_q, 2);
        tick();
        check("idle_out_valid", bus.out_valid, 0);
        check("idle_sel_kept", bus.out_sel, 1);

        // T1: assert reset asynchronously while a beat is stalled.
        bus.in_valid  = 4'b1000;
        bus.in_data   = {8'h77, 8'h00, 8'h00, 8'h00};
        bus.out_ready = 1'b0;
        tick();
        check("t1_held_valid", bus.out_valid, 1);
        check("t1_held_sel", bus.out_sel, 3);
        bus.in_valid = 4'b1111;
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("t1_async_out_valid", bus.out_valid, 0);
        check("t1_async_in_ready", bus.in_ready, 4'b0000);
        check("t1_async_rr_ptr", dut.rr_ptr_q, 0);
        bus.in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 check("t1_in_ready_in_reset", bus.in_ready, 4'b0000);
        #2 rst_n = 1'b1;
        #1 check("t1_first_grant_ch0", bus.in_ready, 4'b0001);

        // T3: all channels are valid, so the mux rotates with no bubble between beats.
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_out_valid", bus.out_valid, 1);
            check("t3_out_sel", bus.out_sel, 32'(i % 4));
            check("t3_out_data", bus.out_data, 32'(8'h10 + i % 4));
        end

        // T4: stall the output for 3 cycles while holding the ch0 beat.
        bus.out_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            #1;
            check("t4_stall_sel", bus.out_sel, 0);
            check("t4_stall_data", bus.out_data, 8'h10);
            check("t4_stall_in_ready", bus.in_ready, 4'b0000);
            tick();
        end
        bus.out_ready = 1'b1;
        #1 check("t4_release_in_ready", bus.in_ready, 4'b0010);
        tick();
        check("t4_next_sel", bus.out_sel, 1);
        check("t4_next_data", bus.out_data, 8'h11);

        // T6: ch0 sends a 3-beat packet while ch1 stays valid throughout.
        bus.in_valid = 4'b0000;
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        tick();
`ifdef STREAM_MUX_PKT_LOCK_EN
        exp_sel  = '{0, 0, 0, 1};
        exp_last = '{0, 0, 1, 1};
`else
        exp_sel  = '{0, 1, 0, 1};
        exp_last = '{0, 1, 0, 1};
`endif
        beat = 0;
        for (int c = 0; c < 4; c++) begin
            bus.in_valid = {2'b00, 1'b1, (beat < 3)};
            bus.in_data  = {8'h00, 8'h00, 8'hB0, 8'(8'hA0 + beat)};
            bus.in_last  = {2'b00, 1'b1, (beat == 2)};
            #1 rdy = bus.in_ready;
            tick();
            check("t6_out_sel", bus.out_sel, 32'(exp_sel[c]));
            check("t6_out_last", bus.out_last, 32'(exp_last[c]));
            if (rdy[0]) beat++;
        end
        bus.in_valid = 4'b0000;
        bus.in_last  = 4'b0000;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
